// File: rtl/beam_threshold_loader.sv
// ============================================================================
// Module      : beam_threshold_loader
// Description : Shadow bank of per-beam thresholds streamed onto the beamformer
//               threshold bus on commit, followed by a single update strobe.
//               Optional periodic commit: define BEAM_THRESH_AUTOCOMMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_threshold_loader #(
    parameter int          NBEAMS         = 2,
    parameter logic [17:0] THRESH_DEFAULT = 18'h3FFFF,
    parameter int          AUTO_PERIOD    = 125000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [5:0]        wr_addr_i,
    input  logic [17:0]       wr_data_i,
    output logic              wr_err_o,
    input  logic              commit_i,
    input  logic              auto_en_i,
    output logic [17:0]       thresh_o,
    output logic [NBEAMS-1:0] thresh_ce_o,
    output logic              update_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       commit_cnt_o
);

    localparam int                 c_idx_w    = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NBEAMS - 1);
    localparam logic [NBEAMS-1:0]  c_ce_one   = NBEAMS'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_pending;
    logic [17:0]          r_shadow [NBEAMS];
    logic [17:0]          r_thresh;
    logic [NBEAMS-1:0]    r_ce;
    logic                 r_update;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_wr_err;
    logic [15:0]          r_commit_cnt;
    logic                 w_addr_ok;
    logic                 w_commit;

    // 7-bit compare so NBEAMS = 64 does not wrap the 6-bit address range
    assign w_addr_ok = ({1'b0, wr_addr_i} < 7'(NBEAMS));

`ifdef BEAM_THRESH_AUTOCOMMIT_EN
    logic [31:0] r_auto_cnt;
    logic        w_auto_commit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_auto_cnt <= '0;
        end else if (!auto_en_i) begin
            r_auto_cnt <= '0;
        end else if (r_auto_cnt == 32'(AUTO_PERIOD - 1)) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 32'd1;
        end
    end

    assign w_auto_commit = auto_en_i && (r_auto_cnt == 32'(AUTO_PERIOD - 1));
    assign w_commit      = commit_i | w_auto_commit;
`else
    localparam int c_unused_period = AUTO_PERIOD;
    logic          w_unused_auto_en;

    assign w_unused_auto_en = auto_en_i;
    assign w_commit         = commit_i;
`endif

    // Shadow bank: writes land every cycle, even while a load is streaming
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NBEAMS; b++) begin
                r_shadow[b] <= THRESH_DEFAULT;
            end
            r_wr_err <= 1'b0;
        end else begin
            for (int b = 0; b < NBEAMS; b++) begin
                if (wr_en_i && (wr_addr_i == 6'(b))) begin
                    r_shadow[b] <= wr_data_i;
                end
            end
            r_wr_err <= wr_en_i && !w_addr_ok;
        end
    end

    // Load sequencer; shadow is read live at each beam's LOAD step
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_thresh     <= '0;
            r_ce         <= '0;
            r_update     <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_commit_cnt <= '0;
        end else begin
            r_update <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_commit || r_pending) begin
                        r_state   <= S_LOAD;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_busy   <= 1'b1;
                    r_thresh <= r_shadow[r_idx];
                    r_ce     <= c_ce_one << r_idx;
                    if (w_commit) begin
                        r_pending <= 1'b1;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= S_UPDATE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_busy       <= 1'b1;
                    r_ce         <= '0;
                    r_update     <= 1'b1;
                    r_done       <= 1'b1;
                    r_commit_cnt <= r_commit_cnt + 16'd1;
                    if (w_commit) begin
                        r_pending <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_err_o     = r_wr_err;
    assign thresh_o     = r_thresh;
    assign thresh_ce_o  = r_ce;
    assign update_o     = r_update;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign commit_cnt_o = r_commit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_beam_threshold_loader.sv
// ============================================================================
// Module      : tb_beam_threshold_loader
// Description : Directed self-checking bench for beam_threshold_loader, NBEAMS=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beam_threshold_loader;

    localparam int c_nbeams = 4;

    logic                clk_i;
    logic                rst_ni;
    logic                wr_en_i;
    logic [5:0]          wr_addr_i;
    logic [17:0]         wr_data_i;
    logic                wr_err_o;
    logic                commit_i;
    logic                auto_en_i;
    logic [17:0]         thresh_o;
    logic [c_nbeams-1:0] thresh_ce_o;
    logic                update_o;
    logic                busy_o;
    logic                done_o;
    logic [15:0]         commit_cnt_o;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_cnt;

    beam_threshold_loader #(
        .NBEAMS        (c_nbeams),
        .THRESH_DEFAULT(18'h3FFFF),
        .AUTO_PERIOD   (20)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_err_o    (wr_err_o),
        .commit_i    (commit_i),
        .auto_en_i   (auto_en_i),
        .thresh_o    (thresh_o),
        .thresh_ce_o (thresh_ce_o),
        .update_o    (update_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .commit_cnt_o(commit_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        commit_i  = 1'b0;
        auto_en_i = 1'b0;
        exp_cnt   = '0;
        repeat (2) tick();
        n_checks++;
        if (thresh_o !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_thresh: got %h expected 00000", thresh_o);
        end
        n_checks++;
        if ({thresh_ce_o, update_o, busy_o, done_o, wr_err_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got ce=%b upd=%b busy=%b done=%b err=%b expected all 0",
                     thresh_ce_o, update_o, busy_o, done_o, wr_err_o);
        end
        n_checks++;
        if (commit_cnt_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h expected 0000", commit_cnt_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic_commit();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_c0: got %b expected 0", busy_o);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (thresh_ce_o !== 4'(1 << (k - 1)) || thresh_o !== 18'h3FFFF || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_load_c%0d: got ce=%b thr=%h busy=%b expected ce=%b thr=3ffff busy=1",
                         k, thresh_ce_o, thresh_o, busy_o, 4'(1 << (k - 1)));
            end
        end
        tick();
        exp_cnt++;
        n_checks++;
        if (update_o !== 1'b1 || done_o !== 1'b1 || thresh_ce_o !== 4'b0000 || commit_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL basic_update_c5: got upd=%b done=%b ce=%b cnt=%0d expected 1 1 0000 %0d",
                     update_o, done_o, thresh_ce_o, commit_cnt_o, exp_cnt);
        end
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || update_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_c6: got busy=%b upd=%b done=%b expected 0 0 0", busy_o, update_o, done_o);
        end
    endtask

    task automatic test_write_and_commit();
        wr_en_i   = 1'b1;
        wr_addr_i = 6'd2;
        wr_data_i = 18'h00123;
        commit_i  = 1'b1;
        tick();
        wr_en_i  = 1'b0;
        commit_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (thresh_ce_o !== 4'b0100 || thresh_o !== 18'h00123) begin
            n_fail++;
            $display("FAIL wrcommit_c3: got ce=%b thr=%h expected ce=0100 thr=00123", thresh_ce_o, thresh_o);
        end
        repeat (3) tick();
        exp_cnt++;
        n_checks++;
        if (commit_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrcommit_cnt: got %0d expected %0d", commit_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ce;
        logic       exp_upd;
        logic       exp_busy;
        for (int c = 0; c <= 12; c++) begin
            commit_i = (c == 0 || c == 2 || c == 3);
            tick();
            commit_i = 1'b0;
            exp_ce   = 4'b0000;
            if (c >= 1 && c <= 4) exp_ce = 4'(1 << (c - 1));
            if (c >= 7 && c <= 10) exp_ce = 4'(1 << (c - 7));
            exp_upd  = (c == 5 || c == 11);
            exp_busy = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
            n_checks++;
            if (thresh_ce_o !== exp_ce || update_o !== exp_upd || busy_o !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b_c%0d: got ce=%b upd=%b busy=%b expected ce=%b upd=%b busy=%b",
                         c, thresh_ce_o, update_o, busy_o, exp_ce, exp_upd, exp_busy);
            end
        end
        exp_cnt = exp_cnt + 16'd2;
        n_checks++;
        if (commit_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d expected %0d", commit_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_write_during_load();
        logic [17:0] exp_v [4];
        // Out-of-range write: flagged, dropped (0x15555 must not show up anywhere)
        wr_en_i   = 1'b1;
        wr_addr_i = 6'd4;
        wr_data_i = 18'h15555;
        tick();
        wr_en_i = 1'b0;
        n_checks++;
        if (wr_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_pulse: got %b expected 1", wr_err_o);
        end
        tick();
        n_checks++;
        if (wr_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_clear: got %b expected 0", wr_err_o);
        end
        // Beam 0 rewritten after it was loaded: old value this time
        exp_v[0] = 18'h3FFFF;
        exp_v[1] = 18'h3FFFF;
        exp_v[2] = 18'h00123;
        exp_v[3] = 18'h3FFFF;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            wr_en_i = 1'b0;
            if (k <= 4) begin
                n_checks++;
                if (thresh_o !== exp_v[k-1] || thresh_ce_o !== 4'(1 << (k - 1))) begin
                    n_fail++;
                    $display("FAIL wrload1_beam%0d: got thr=%h ce=%b expected thr=%h ce=%b",
                             k - 1, thresh_o, thresh_ce_o, exp_v[k-1], 4'(1 << (k - 1)));
                end
            end
            if (k == 2) begin
                wr_en_i   = 1'b1;
                wr_addr_i = 6'd0;
                wr_data_i = 18'h0AAAA;
            end
        end
        // Next commit: new beam 0, and beam 3 rewritten before its load step
        exp_v[0] = 18'h0AAAA;
        exp_v[3] = 18'h00777;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            wr_en_i = 1'b0;
            if (k <= 4) begin
                n_checks++;
                if (thresh_o !== exp_v[k-1] || thresh_ce_o !== 4'(1 << (k - 1))) begin
                    n_fail++;
                    $display("FAIL wrload2_beam%0d: got thr=%h ce=%b expected thr=%h ce=%b",
                             k - 1, thresh_o, thresh_ce_o, exp_v[k-1], 4'(1 << (k - 1)));
                end
            end
            if (k == 1) begin
                wr_en_i   = 1'b1;
                wr_addr_i = 6'd3;
                wr_data_i = 18'h00777;
            end
        end
        exp_cnt = exp_cnt + 16'd2;
        n_checks++;
        if (commit_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrload_cnt: got %0d expected %0d", commit_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_sequence();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (thresh_ce_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_pre: got ce=%b expected 0010", thresh_ce_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (thresh_o !== 18'h0 || {thresh_ce_o, update_o, busy_o, done_o, wr_err_o} !== 8'h00
            || commit_cnt_o !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got thr=%h ce=%b upd=%b busy=%b done=%b err=%b cnt=%0d expected all 0",
                     thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o, commit_cnt_o);
        end
        repeat (3) tick();
        n_checks++;
        if (update_o !== 1'b0 || busy_o !== 1'b0 || commit_cnt_o !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_held: got upd=%b busy=%b cnt=%0d expected 0 0 0", update_o, busy_o, commit_cnt_o);
        end
        @(negedge clk_i);
        rst_ni  = 1'b1;
        exp_cnt = '0;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (thresh_o !== 18'h3FFFF || thresh_ce_o !== 4'(1 << (k - 1))) begin
                n_fail++;
                $display("FAIL rstmid_shadow_beam%0d: got thr=%h ce=%b expected thr=3ffff ce=%b",
                         k - 1, thresh_o, thresh_ce_o, 4'(1 << (k - 1)));
            end
        end
        repeat (2) tick();
        exp_cnt++;
        n_checks++;
        if (commit_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL rstmid_cnt: got %0d expected %0d", commit_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_auto_commit();
        int busy_cycles;
        busy_cycles = 0;
        auto_en_i   = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (busy_o === 1'b1) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 0) begin
            n_fail++;
            $display("FAIL auto_off_idle: got %0d busy cycles expected 0", busy_cycles);
        end
`ifdef BEAM_THRESH_AUTOCOMMIT_EN
        begin
            int starts;
            int last_start;
            starts     = 0;
            last_start = -1;
            auto_en_i  = 1'b1;
            for (int c = 0; c < 80; c++) begin
                tick();
                if (thresh_ce_o === 4'b0001) begin
                    if (last_start >= 0) begin
                        n_checks++;
                        if (c - last_start != 20) begin
                            n_fail++;
                            $display("FAIL auto_period: got gap %0d expected 20", c - last_start);
                        end
                    end
                    last_start = c;
                    starts++;
                end
            end
            auto_en_i = 1'b0;
            n_checks++;
            if (starts < 3) begin
                n_fail++;
                $display("FAIL auto_starts: got %0d sequences expected at least 3", starts);
            end
            repeat (10) tick();
        end
`else
        auto_en_i   = 1'b1;
        busy_cycles = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (busy_o === 1'b1) busy_cycles++;
        end
        auto_en_i = 1'b0;
        n_checks++;
        if (busy_cycles != 0 || commit_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL auto_ignored: got %0d busy cycles cnt=%0d expected 0 busy cnt=%0d",
                     busy_cycles, commit_cnt_o, exp_cnt);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_commit();
        test_write_and_commit();
        test_back_to_back();
        test_write_during_load();
        test_reset_mid_sequence();
        test_auto_commit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
